mailbox_read_arbiter: RTL and testbench

MAILBOX_READ_ARBITER -- requirements
Module: mailbox_read_arbiter

---
 rtl/mailbox_read_arbiter_pkg.sv | 18 +
 rtl/mailbox_read_arbiter_if.sv | 49 ++++
 rtl/mailbox_rr_arbiter.sv | 30 +++
 rtl/mailbox_read_arbiter.sv | 148 ++++++++++++++
 tb/tb_mailbox_read_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mailbox_read_arbiter_pkg.sv
// Shared types and constants for the mailbox read arbiter.
// Optional feature macro: MBOX_ARB_BURST_REJECT_EN (adds the ERR state).
package mailbox_read_arbiter_pkg;

    // Arbiter FSM states; ERR exists only when burst rejection is compiled in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
`ifdef MBOX_ARB_BURST_REJECT_EN
        , ST_ERR = 2'd3
`endif
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/mailbox_read_arbiter_if.sv
// Bundle of the two requester AR/R channels and the adaptor AR/R channel.
// slave  : the arbiter's view (serves requesters, drives the adaptor).
// master : the environment's view (requesters plus the adaptor).
// Handshake rule on every channel: a beat transfers on a rising clock edge
// where valid and ready are both high; once raised, valid and its payload
// stay stable until that transfer.
interface mailbox_read_arbiter_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10
);
    logic [1:0][AXI_ADDR_WIDTH-1:0] Req_ArAddr_DI;
    logic [1:0]                     Req_ArValid_SI;
    logic [1:0]                     Req_ArReady_SO;
    logic [1:0][7:0]                Req_ArLen_SI;
    logic [1:0][AXI_ID_WIDTH-1:0]   Req_ArId_DI;
    logic [1:0]                     Req_RValid_SO;
    logic [1:0]                     Req_RReady_SI;
    logic [AXI_DATA_WIDTH-1:0]      Req_RData_DO;
    logic [AXI_ID_WIDTH-1:0]        Req_RId_DO;
    logic [1:0]                     Req_RResp_DO;
    logic                           Req_RLast_SO;

    logic [AXI_ADDR_WIDTH-1:0]      Mbx_ArAddr_DO;
    logic [7:0]                     Mbx_ArLen_SO;
    logic [AXI_ID_WIDTH-1:0]        Mbx_ArId_DO;
    logic                           Mbx_ArValid_SO;
    logic                           Mbx_ArReady_SI;
    logic [AXI_DATA_WIDTH-1:0]      Mbx_RData_DI;
    logic [AXI_ID_WIDTH-1:0]        Mbx_RId_DI;
    logic [1:0]                     Mbx_RResp_DI;
    logic                           Mbx_RValid_SI;
    logic                           Mbx_RReady_SO;

    modport slave (
        input  Req_ArAddr_DI, Req_ArValid_SI, Req_ArLen_SI, Req_ArId_DI, Req_RReady_SI,
        output Req_ArReady_SO, Req_RValid_SO, Req_RData_DO, Req_RId_DO, Req_RResp_DO, Req_RLast_SO,
        output Mbx_ArAddr_DO, Mbx_ArLen_SO, Mbx_ArId_DO, Mbx_ArValid_SO, Mbx_RReady_SO,
        input  Mbx_ArReady_SI, Mbx_RData_DI, Mbx_RId_DI, Mbx_RResp_DI, Mbx_RValid_SI
    );

    modport master (
        output Req_ArAddr_DI, Req_ArValid_SI, Req_ArLen_SI, Req_ArId_DI, Req_RReady_SI,
        input  Req_ArReady_SO, Req_RValid_SO, Req_RData_DO, Req_RId_DO, Req_RResp_DO, Req_RLast_SO,
        input  Mbx_ArAddr_DO, Mbx_ArLen_SO, Mbx_ArId_DO, Mbx_ArValid_SO, Mbx_RReady_SO,
        output Mbx_ArReady_SI, Mbx_RData_DI, Mbx_RId_DI, Mbx_RResp_DI, Mbx_RValid_SI
    );

endinterface

// File: rtl/mailbox_rr_arbiter.sv
// Two-way round-robin grant. A lone request always wins; on a tie the
// priority bit picks the winner, and after every accepted grant the bit
// points at the requester that did not win.
module mailbox_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       prio
);

    // One-hot grant from the current requests and priority bit.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end
    end

    // Priority flips to the loser whenever a grant is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (advance) begin
            prio <= grant[0];
        end
    end

endmodule

// File: rtl/mailbox_read_arbiter.sv
// Shares one mailbox read adaptor between two AXI-style read requesters,
// one transaction outstanding at a time.
// Optional feature macro: MBOX_ARB_BURST_REJECT_EN -- when defined, requests
// with a nonzero burst length are answered locally with SLVERR.
module mailbox_read_arbiter
    import mailbox_read_arbiter_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10
) (
    input  logic                   Clk_CI,
    input  logic                   Rst_RI,
    mailbox_read_arbiter_if.slave  bus,
    output state_e                 dbg_state,
    output logic                   dbg_prio
);

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic                      winner_q;

    logic [1:0]                grant;
    logic                      prio;
    logic                      sel;
    logic                      ar_hs;

    logic [1:0]                ar_ready;
    logic                      mbx_ar_valid;
    logic [1:0]                r_valid;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic                      mbx_r_ready;

    // Grant is nonzero exactly when some requester is valid, so any valid
    // in IDLE is a completed handshake with the winner.
    assign sel   = grant[1];
    assign ar_hs = (state_q == ST_IDLE) && (|bus.Req_ArValid_SI);

    mailbox_rr_arbiter u_rr (
        .clk     (Clk_CI),
        .rst     (Rst_RI),
        .req     (bus.Req_ArValid_SI),
        .advance (ar_hs),
        .grant   (grant),
        .prio    (prio)
    );

    // State register.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winning request payload at the AR handshake.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            addr_q   <= '0;
            len_q    <= '0;
            id_q     <= '0;
            winner_q <= 1'b0;
        end else if (ar_hs) begin
            addr_q   <= bus.Req_ArAddr_DI[sel];
            len_q    <= bus.Req_ArLen_SI[sel];
            id_q     <= bus.Req_ArId_DI[sel];
            winner_q <= sel;
        end
    end

    // Next state and all handshake/R outputs; R outputs are zero outside DATA/ERR.
    always_comb begin
        state_d      = state_q;
        ar_ready     = 2'b00;
        mbx_ar_valid = 1'b0;
        r_valid      = 2'b00;
        r_data       = '0;
        r_id         = '0;
        r_resp       = RESP_OKAY;
        r_last       = 1'b0;
        mbx_r_ready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ar_ready = grant;
                if (ar_hs) begin
`ifdef MBOX_ARB_BURST_REJECT_EN
                    state_d = (bus.Req_ArLen_SI[sel] != 8'd0) ? ST_ERR : ST_ADDR;
`else
                    state_d = ST_ADDR;
`endif
                end
            end
            ST_ADDR: begin
                mbx_ar_valid = 1'b1;
                if (bus.Mbx_ArReady_SI) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                r_valid[winner_q] = bus.Mbx_RValid_SI;
                mbx_r_ready       = bus.Req_RReady_SI[winner_q];
                r_data            = bus.Mbx_RData_DI;
                r_resp            = bus.Mbx_RResp_DI;
                r_id              = id_q;
                r_last            = bus.Mbx_RValid_SI;
                if (bus.Mbx_RValid_SI && mbx_r_ready) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef MBOX_ARB_BURST_REJECT_EN
            ST_ERR: begin
                r_valid[winner_q] = 1'b1;
                r_resp            = RESP_SLVERR;
                r_id              = id_q;
                r_last            = 1'b1;
                if (bus.Req_RReady_SI[winner_q]) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.Req_ArReady_SO = ar_ready;
    assign bus.Req_RValid_SO  = r_valid;
    assign bus.Req_RData_DO   = r_data;
    assign bus.Req_RId_DO     = r_id;
    assign bus.Req_RResp_DO   = r_resp;
    assign bus.Req_RLast_SO   = r_last;
    assign bus.Mbx_ArAddr_DO  = addr_q;
    assign bus.Mbx_ArLen_SO   = len_q;
    assign bus.Mbx_ArId_DO    = id_q;
    assign bus.Mbx_ArValid_SO = mbx_ar_valid;
    assign bus.Mbx_RReady_SO  = mbx_r_ready;

    assign dbg_state = state_q;
    assign dbg_prio  = prio;

endmodule

// File: tb/tb_mailbox_read_arbiter.sv
// Directed bench for mailbox_read_arbiter: a table of single transactions
// plus hand-written sequences for stalls, reset mid-transaction and bursts.
// Optional feature macro: MBOX_ARB_BURST_REJECT_EN selects the burst check.
module tb_mailbox_read_arbiter;
    import mailbox_read_arbiter_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_e dbg_state;
    logic   dbg_prio;
    int     n_total = 0;
    int     n_pass  = 0;

    mailbox_read_arbiter_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10)) bus ();

    mailbox_read_arbiter #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10)) dut (
        .Clk_CI    (clk),
        .Rst_RI    (rst),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_prio  (dbg_prio)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [9:0]  id0;
        logic [9:0]  id1;
        logic [63:0] rdata;
        logic        exp_win;
        logic [31:0] exp_addr;
        logic [9:0]  exp_id;
        logic        exp_prio;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(logic [1:0] valid, logic [31:0] a0, logic [31:0] a1,
                                logic [9:0] i0, logic [9:0] i1, logic [63:0] d,
                                logic win, logic [31:0] ea, logic [9:0] ei, logic ep);
        vec_t v;
        v.valid = valid; v.addr0 = a0; v.addr1 = a1; v.id0 = i0; v.id1 = i1;
        v.rdata = d; v.exp_win = win; v.exp_addr = ea; v.exp_id = ei; v.exp_prio = ep;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(logic [1:0] valid, logic [31:0] a0, logic [31:0] a1,
                             logic [9:0] i0, logic [9:0] i1, logic [7:0] len);
        bus.Req_ArValid_SI = valid;
        bus.Req_ArAddr_DI[0] = a0;
        bus.Req_ArAddr_DI[1] = a1;
        bus.Req_ArId_DI[0] = i0;
        bus.Req_ArId_DI[1] = i1;
        bus.Req_ArLen_SI[0] = len;
        bus.Req_ArLen_SI[1] = len;
    endtask

    // Accept the AR on the adaptor side: one cycle with Mbx_ArReady_SI high.
    task automatic adaptor_accept();
        bus.Mbx_ArReady_SI = 1'b1;
        tick();
        bus.Mbx_ArReady_SI = 1'b0;
    endtask

    // One complete transaction from a table row, starting in IDLE.
    task automatic run_vec(vec_t v, int idx);
        string s;
        s = $sformatf("v%0d", idx);
        drive_req(v.valid, v.addr0, v.addr1, v.id0, v.id1, 8'd0);
        #1;
        check({s, "_ar_ready"}, bus.Req_ArReady_SO, v.exp_win ? 2'b10 : 2'b01);
        check({s, "_ar_valid_idle"}, bus.Mbx_ArValid_SO, 1'b0);
        tick();
        bus.Req_ArValid_SI = 2'b00;
        #1;
        check({s, "_ar_valid"}, bus.Mbx_ArValid_SO, 1'b1);
        check({s, "_ar_addr"}, bus.Mbx_ArAddr_DO, v.exp_addr);
        check({s, "_ar_id"}, bus.Mbx_ArId_DO, v.exp_id);
        adaptor_accept();
        bus.Mbx_RValid_SI = 1'b1;
        bus.Mbx_RData_DI = v.rdata;
        bus.Mbx_RResp_DI = RESP_OKAY;
        bus.Mbx_RId_DI = ~v.exp_id;
        #1;
        check({s, "_r_valid"}, bus.Req_RValid_SO, v.exp_win ? 2'b10 : 2'b01);
        check({s, "_r_data"}, bus.Req_RData_DO, v.rdata);
        check({s, "_r_id"}, bus.Req_RId_DO, v.exp_id);
        check({s, "_r_last"}, bus.Req_RLast_SO, 1'b1);
        check({s, "_mbx_r_ready"}, bus.Mbx_RReady_SO, 1'b1);
        tick();
        bus.Mbx_RValid_SI = 1'b0;
        #1;
        check({s, "_state_idle"}, dbg_state, ST_IDLE);
        check({s, "_prio"}, dbg_prio, v.exp_prio);
    endtask

    initial begin
        drive_req(2'b00, '0, '0, '0, '0, 8'd0);
        bus.Req_RReady_SI  = 2'b11;
        bus.Mbx_ArReady_SI = 1'b0;
        bus.Mbx_RData_DI   = '0;
        bus.Mbx_RId_DI     = '0;
        bus.Mbx_RResp_DI   = RESP_OKAY;
        bus.Mbx_RValid_SI  = 1'b0;

        vecs[0]  = mk(2'b11, 32'h2000, 32'h3000, 10'h040, 10'h080, 64'h1111, 1'b0, 32'h2000, 10'h040, 1'b1);
        vecs[1]  = mk(2'b11, 32'h2004, 32'h3004, 10'h041, 10'h081, 64'h2222, 1'b1, 32'h3004, 10'h081, 1'b0);
        vecs[2]  = mk(2'b11, 32'h2008, 32'h3008, 10'h042, 10'h082, 64'h3333, 1'b0, 32'h2008, 10'h042, 1'b1);
        vecs[3]  = mk(2'b11, 32'h200C, 32'h300C, 10'h043, 10'h083, 64'h4444, 1'b1, 32'h300C, 10'h083, 1'b0);
        vecs[4]  = mk(2'b11, 32'h2010, 32'h3010, 10'h044, 10'h084, 64'h5555, 1'b0, 32'h2010, 10'h044, 1'b1);
        vecs[5]  = mk(2'b11, 32'h2014, 32'h3014, 10'h045, 10'h085, 64'h6666, 1'b1, 32'h3014, 10'h085, 1'b0);
        vecs[6]  = mk(2'b11, 32'h2018, 32'h3018, 10'h046, 10'h086, 64'h7777, 1'b0, 32'h2018, 10'h046, 1'b1);
        vecs[7]  = mk(2'b11, 32'h201C, 32'h301C, 10'h047, 10'h087, 64'h8888, 1'b1, 32'h301C, 10'h087, 1'b0);
        vecs[8]  = mk(2'b10, 32'h9999, 32'h4000, 10'h111, 10'h3AA, 64'hDEAD_BEEF, 1'b1, 32'h4000, 10'h3AA, 1'b0);
        vecs[9]  = mk(2'b01, 32'h1000, 32'h9998, 10'h015, 10'h222, 64'hCAFE, 1'b0, 32'h1000, 10'h015, 1'b1);
        vecs[10] = mk(2'b10, 32'h9997, 32'h5000, 10'h123, 10'h2BC, 64'h0123_4567_89AB_CDEF, 1'b1, 32'h5000, 10'h2BC, 1'b0);
        vecs[11] = mk(2'b01, 32'h6000, 32'h9996, 10'h001, 10'h333, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'h6000, 10'h001, 1'b1);

        // Reset state.
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_prio", dbg_prio, 1'b0);
        check("rst_ar_ready", bus.Req_ArReady_SO, 2'b00);
        check("rst_mbx_ar_valid", bus.Mbx_ArValid_SO, 1'b0);
        check("rst_mbx_r_ready", bus.Mbx_RReady_SO, 1'b0);
        check("rst_r_valid", bus.Req_RValid_SO, 2'b00);
        check("rst_r_data", bus.Req_RData_DO, 64'h0);
        check("rst_ar_addr", bus.Mbx_ArAddr_DO, 32'h0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // AR stall: adaptor not ready for 10 cycles; req1 waits meanwhile and
        // a stray adaptor R valid outside DATA is ignored.
        drive_req(2'b01, 32'h7000, 32'h8000, 10'h077, 10'h088, 8'd0);
        tick();
        bus.Req_ArValid_SI = 2'b10;
        bus.Mbx_RValid_SI = 1'b1;
        bus.Mbx_RData_DI = 64'hABCD;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("stall_ar_valid", bus.Mbx_ArValid_SO, 1'b1);
            check("stall_ar_addr", bus.Mbx_ArAddr_DO, 32'h7000);
            check("stall_ar_id", bus.Mbx_ArId_DO, 10'h077);
            check("stall_ar_ready", bus.Req_ArReady_SO, 2'b00);
            check("stall_mbx_r_ready", bus.Mbx_RReady_SO, 1'b0);
            check("stall_r_valid", bus.Req_RValid_SO, 2'b00);
            tick();
        end
        adaptor_accept();
        bus.Req_RReady_SI = 2'b00;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("rstall_mbx_r_ready", bus.Mbx_RReady_SO, 1'b0);
            check("rstall_r_valid", bus.Req_RValid_SO, 2'b01);
            check("rstall_r_data", bus.Req_RData_DO, 64'hABCD);
            check("rstall_state", dbg_state, ST_DATA);
            tick();
        end
        bus.Req_RReady_SI = 2'b11;
        #1;
        check("rstall_release", bus.Mbx_RReady_SO, 1'b1);
        tick();
        bus.Mbx_RValid_SI = 1'b0;
        #1;
        check("rstall_idle", dbg_state, ST_IDLE);
        check("waiter_ar_ready", bus.Req_ArReady_SO, 2'b10);
        tick();
        bus.Req_ArValid_SI = 2'b00;
        #1;
        check("waiter_ar_addr", bus.Mbx_ArAddr_DO, 32'h8000);
        adaptor_accept();
        bus.Mbx_RValid_SI = 1'b1;
        #1;
        check("waiter_r_valid", bus.Req_RValid_SO, 2'b10);
        tick();
        bus.Mbx_RValid_SI = 1'b0;

        // Reset pulsed during DATA: transaction abandoned, priority restored.
        drive_req(2'b01, 32'h9000, 32'h0, 10'h099, 10'h0, 8'd0);
        tick();
        bus.Req_ArValid_SI = 2'b00;
        adaptor_accept();
        #1;
        check("pre_rst_prio", dbg_prio, 1'b1);
        bus.Mbx_RValid_SI = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_state", dbg_state, ST_IDLE);
        check("midrst_prio", dbg_prio, 1'b0);
        check("midrst_r_valid", bus.Req_RValid_SO, 2'b00);
        check("midrst_mbx_r_ready", bus.Mbx_RReady_SO, 1'b0);
        tick();
        check("midrst_no_beat", bus.Req_RValid_SO, 2'b00);
        bus.Mbx_RValid_SI = 1'b0;

        // Burst request of length 3.
        drive_req(2'b01, 32'hA000, 32'h0, 10'h0AA, 10'h0, 8'd3);
        tick();
        bus.Req_ArValid_SI = 2'b00;
`ifdef MBOX_ARB_BURST_REJECT_EN
        bus.Req_RReady_SI = 2'b00;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("err_state", dbg_state, ST_ERR);
            check("err_ar_valid", bus.Mbx_ArValid_SO, 1'b0);
            check("err_r_valid", bus.Req_RValid_SO, 2'b01);
            check("err_r_resp", bus.Req_RResp_DO, 2'b10);
            check("err_r_last", bus.Req_RLast_SO, 1'b1);
            check("err_r_data", bus.Req_RData_DO, 64'h0);
            check("err_r_id", bus.Req_RId_DO, 10'h0AA);
            tick();
        end
        bus.Req_RReady_SI = 2'b11;
        tick();
        check("err_done_state", dbg_state, ST_IDLE);
        check("err_done_ar_valid", bus.Mbx_ArValid_SO, 1'b0);
`else
        #1;
        check("burst_ar_valid", bus.Mbx_ArValid_SO, 1'b1);
        check("burst_ar_len", bus.Mbx_ArLen_SO, 8'd3);
        adaptor_accept();
        bus.Mbx_RValid_SI = 1'b1;
        bus.Mbx_RResp_DI = RESP_OKAY;
        #1;
        check("burst_r_valid", bus.Req_RValid_SO, 2'b01);
        tick();
        bus.Mbx_RValid_SI = 1'b0;
        #1;
        check("burst_done_state", dbg_state, ST_IDLE);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
